ex_mem_pipe: RTL

Parametrised EX/MEM pipeline stage: successor to the plain EX/MEM register, adding valid/ready handshake, backpressure and flush.
- Implemented as a 2-entry skid buffer: full throughput with a registered ex_ready, so no combinational ready path from MEM back to EX.
- Sits between the execute unit and the memory-access stage.
- Carries writeback target, writeback data, opcode and memory address.

---
 rtl/ex_mem_pipe_pkg.sv | 22 ++
 rtl/ex_mem_pipe_skid.sv | 89 ++++++++
 rtl/ex_mem_pipe.sv | 86 ++++++++
 3 files changed

// File: rtl/ex_mem_pipe_pkg.sv
// ex_mem_pipe_pkg: shared constants and types for the EX/MEM pipeline stage.
//   XLEN, REG_ADDR_W, OP_W : default field widths
//   NONE_OPCODE            : opcode shown on mem_opcode while the stage is empty
//   PAYLOAD_W              : packed payload width {wd, wreg, wdata, opcode, mem_addr}
//   skid_state_e           : occupancy of the 2-entry skid buffer
package ex_mem_pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int OP_W       = 7;

    localparam logic [OP_W-1:0] NONE_OPCODE = 7'b0000000;

    localparam int PAYLOAD_W = REG_ADDR_W + 1 + XLEN + OP_W + XLEN;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/ex_mem_pipe_skid.sv
// pipe_skid_buf: generic W-bit 2-entry skid buffer with valid/ready and flush.
// in_ready is a register, so there is no combinational path from out_ready
// back to in_ready. out_data is always the main entry.
//   clk, rst (async active-low), flush
//   in_valid/in_ready/in_data    : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake
//
// state | meaning
// EMPTY | no entry held
// ONE   | main holds the output entry
// TWO   | main and skid both full, in_ready low
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    import ex_mem_pipe_pkg::*;

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         ready_q;
    logic         acc, pop;

    assign acc       = in_valid & ready_q;
    assign pop       = out_valid & out_ready;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Payload is left as-is; only occupancy is cleared.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != TWO);
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline stage with valid/ready handshake, backpressure
// and flush, built on a 2-entry skid buffer (registered ex_ready).
//   clk, rst (async active-low), flush
//   ex_*  : execute-side op (valid/ready, wd, wreg, wdata, opcode, mem_addr)
//   mem_* : memory-side op; mem_wreg is gated by mem_valid, mem_opcode shows
//           NONE_OPCODE while empty
// Optional: define EX_MEM_PERF_EN to add saturating stall_cnt/flush_cnt outputs.
module ex_mem_pipe #(
    parameter int XLEN       = ex_mem_pipe_pkg::XLEN,
    parameter int REG_ADDR_W = ex_mem_pipe_pkg::REG_ADDR_W,
    parameter int OP_W       = ex_mem_pipe_pkg::OP_W,
    parameter logic [OP_W-1:0] NONE_OPCODE = OP_W'(ex_mem_pipe_pkg::NONE_OPCODE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [XLEN-1:0]       ex_wdata,
    input  logic [OP_W-1:0]       ex_opcode,
    input  logic [XLEN-1:0]       ex_mem_addr,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [OP_W-1:0]       mem_opcode,
    output logic [XLEN-1:0]       mem_mem_addr
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [15:0]           flush_cnt
`endif
);
    import ex_mem_pipe_pkg::*;

    localparam int PLD_W = REG_ADDR_W + 1 + XLEN + OP_W + XLEN;

    logic [PLD_W-1:0]      in_pld, out_pld;
    logic [REG_ADDR_W-1:0] main_wd;
    logic                  main_wreg;
    logic [OP_W-1:0]       main_opcode;

    assign in_pld = {ex_wd, ex_wreg, ex_wdata, ex_opcode, ex_mem_addr};

    pipe_skid_buf #(.W(PLD_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (ex_valid),
        .in_ready  (ex_ready),
        .in_data   (in_pld),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .out_data  (out_pld)
    );

    assign {main_wd, main_wreg, mem_wdata, main_opcode, mem_mem_addr} = out_pld;

    assign mem_wd     = main_wd;
    assign mem_wreg   = main_wreg & mem_valid;
    assign mem_opcode = mem_valid ? main_opcode : NONE_OPCODE;

`ifdef EX_MEM_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (mem_valid && !mem_ready && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && mem_valid && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
